dd_outgoing_sel: RTL and testbench

- Transmit-side counterpart of the incoming-ACK event processor.
- Takes a flow's window context when the flow is scheduled to send, and picks the next segment: either the oldest pending retransmission or the next new sequence number.
- Returns the updated context to the flow context memory, together with a transmit descriptor.
- Scans the retransmit bitmap in chunks over several cycles, so the window can be large without a single wide priority encoder.

---
 rtl/dd_outgoing_sel.sv | 193 +++++++++++++++++++
 tb/tb_dd_outgoing_sel.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dd_outgoing_sel.sv
// rtl/dd_outgoing_sel.sv - per-flow transmit segment selector (rtx-first, chunked bitmap scan)
// Optional DD_OUTGOING_STATS_EN adds saturating result-type counters.
module dd_outgoing_sel #(
  parameter int FLOW_WIN_SIZE  = 128,
  parameter int FLOW_WIN_IND_W = 7,
  parameter int SCAN_CHUNK     = 32,
  parameter int SEQ_W          = 32,
  parameter int FLOW_ID_W      = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FLOW_ID_W-1:0]      in_flow_id,
  input  logic [FLOW_WIN_SIZE-1:0]  in_acked_wnd,
  input  logic [FLOW_WIN_SIZE-1:0]  in_rtx_wnd,
  input  logic [SEQ_W-1:0]          in_wnd_start,
  input  logic [FLOW_WIN_IND_W-1:0] in_wnd_start_ind,
  input  logic [FLOW_WIN_IND_W:0]   in_wnd_size,
  input  logic [SEQ_W-1:0]          in_next_new,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FLOW_ID_W-1:0]      out_flow_id,
  output logic                      out_pkt_val,
  output logic                      out_pkt_rtx,
  output logic [SEQ_W-1:0]          out_pkt_seq,
  output logic [FLOW_WIN_SIZE-1:0]  out_rtx_wnd,
  output logic [SEQ_W-1:0]          out_next_new
`ifdef DD_OUTGOING_STATS_EN
  ,
  output logic [31:0]               stat_rtx_cnt,
  output logic [31:0]               stat_new_cnt,
  output logic [31:0]               stat_none_cnt
`endif
);

  localparam int SCAN_IND_W = $clog2(SCAN_CHUNK);
  localparam int CHUNK_W    = FLOW_WIN_IND_W - SCAN_IND_W;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(FLOW_WIN_SIZE / SCAN_CHUNK - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE, EMIT} state_t;
  state_t state, state_nxt;

  logic [FLOW_ID_W-1:0]      flow_id_q;
  logic [FLOW_WIN_SIZE-1:0]  acked_q;
  logic [FLOW_WIN_SIZE-1:0]  rtx_q;
  logic [SEQ_W-1:0]          wnd_start_q;
  logic [FLOW_WIN_IND_W-1:0] start_ind_q;
  logic [FLOW_WIN_IND_W:0]   wnd_size_q;
  logic [SEQ_W-1:0]          next_new_q;
  logic [CHUNK_W-1:0]        chunk_q;
  logic                      found_q;
  logic [FLOW_WIN_IND_W-1:0] off_q;

  logic                      scan_hit;
  logic [SCAN_IND_W-1:0]     scan_j;
  logic [FLOW_WIN_IND_W-1:0] scan_off;
  logic [FLOW_WIN_IND_W-1:0] scan_phys;

  logic [FLOW_WIN_IND_W-1:0] hit_phys;
  logic [FLOW_WIN_SIZE-1:0]  rtx_cleared;
  logic [SEQ_W-1:0]          new_dist;
  logic                      new_ok;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);

  // Lowest candidate offset within the current chunk; physical index wraps via the
  // natural FLOW_WIN_IND_W-bit addition.
  always_comb begin
    scan_hit  = 1'b0;
    scan_j    = '0;
    scan_off  = '0;
    scan_phys = '0;
    for (int j = SCAN_CHUNK - 1; j >= 0; j--) begin
      scan_off  = {chunk_q, SCAN_IND_W'(j)};
      scan_phys = start_ind_q + scan_off;
      if (rtx_q[scan_phys] && !acked_q[scan_phys] && ({1'b0, scan_off} < wnd_size_q)) begin
        scan_hit = 1'b1;
        scan_j   = SCAN_IND_W'(j);
      end
    end
  end

  always_comb begin
    hit_phys              = start_ind_q + off_q;
    rtx_cleared           = rtx_q;
    rtx_cleared[hit_phys] = 1'b0;
    new_dist              = next_new_q - wnd_start_q;
    new_ok                = (new_dist < SEQ_W'(wnd_size_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SCAN;
      SCAN:    if (scan_hit || (chunk_q == LAST_CHUNK)) state_nxt = DECIDE;
      DECIDE:  state_nxt = EMIT;
      EMIT:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flow_id_q    <= '0;
      acked_q      <= '0;
      rtx_q        <= '0;
      wnd_start_q  <= '0;
      start_ind_q  <= '0;
      wnd_size_q   <= '0;
      next_new_q   <= '0;
      chunk_q      <= '0;
      found_q      <= 1'b0;
      off_q        <= '0;
      out_flow_id  <= '0;
      out_pkt_val  <= 1'b0;
      out_pkt_rtx  <= 1'b0;
      out_pkt_seq  <= '0;
      out_rtx_wnd  <= '0;
      out_next_new <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          flow_id_q   <= in_flow_id;
          acked_q     <= in_acked_wnd;
          rtx_q       <= in_rtx_wnd;
          wnd_start_q <= in_wnd_start;
          start_ind_q <= in_wnd_start_ind;
          wnd_size_q  <= in_wnd_size;
          next_new_q  <= in_next_new;
          chunk_q     <= '0;
          found_q     <= 1'b0;
        end
        SCAN: begin
          if (scan_hit) begin
            found_q <= 1'b1;
            off_q   <= {chunk_q, scan_j};
          end else begin
            chunk_q <= chunk_q + CHUNK_W'(1);
          end
        end
        DECIDE: begin
          out_flow_id <= flow_id_q;
          if (found_q) begin
            out_pkt_val  <= 1'b1;
            out_pkt_rtx  <= 1'b1;
            out_pkt_seq  <= wnd_start_q + SEQ_W'(off_q);
            out_rtx_wnd  <= rtx_cleared;
            out_next_new <= next_new_q;
          end else if (new_ok) begin
            out_pkt_val  <= 1'b1;
            out_pkt_rtx  <= 1'b0;
            out_pkt_seq  <= next_new_q;
            out_rtx_wnd  <= rtx_q;
            out_next_new <= next_new_q + SEQ_W'(1);
          end else begin
            out_pkt_val  <= 1'b0;
            out_pkt_rtx  <= 1'b0;
            out_pkt_seq  <= '0;
            out_rtx_wnd  <= rtx_q;
            out_next_new <= next_new_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DD_OUTGOING_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rtx_cnt  <= '0;
      stat_new_cnt  <= '0;
      stat_none_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (!out_pkt_val) begin
        if (stat_none_cnt != '1) stat_none_cnt <= stat_none_cnt + 32'd1;
      end else if (out_pkt_rtx) begin
        if (stat_rtx_cnt != '1) stat_rtx_cnt <= stat_rtx_cnt + 32'd1;
      end else begin
        if (stat_new_cnt != '1) stat_new_cnt <= stat_new_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dd_outgoing_sel.sv
// tb/tb_dd_outgoing_sel.sv - randomized + directed bench for dd_outgoing_sel against a behavioural model
module tb_dd_outgoing_sel;

  typedef struct {
    logic [9:0]   flow_id;
    logic [127:0] acked;
    logic [127:0] rtx;
    logic [31:0]  start;
    logic [6:0]   ind;
    logic [7:0]   size;
    logic [31:0]  nn;
  } txn_t;

  typedef struct {
    logic [9:0]   flow_id;
    logic         val;
    logic         rtx;
    logic [31:0]  seq;
    logic [127:0] rtxw;
    logic [31:0]  nn;
    int           lat;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [9:0]   in_flow_id = '0;
  logic [127:0] in_acked_wnd = '0;
  logic [127:0] in_rtx_wnd = '0;
  logic [31:0]  in_wnd_start = '0;
  logic [6:0]   in_wnd_start_ind = '0;
  logic [7:0]   in_wnd_size = '0;
  logic [31:0]  in_next_new = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [9:0]   out_flow_id;
  logic         out_pkt_val;
  logic         out_pkt_rtx;
  logic [31:0]  out_pkt_seq;
  logic [127:0] out_rtx_wnd;
  logic [31:0]  out_next_new;
`ifdef DD_OUTGOING_STATS_EN
  logic [31:0]  stat_rtx_cnt, stat_new_cnt, stat_none_cnt;
  int           exp_rtx_cnt = 0, exp_new_cnt = 0, exp_none_cnt = 0;
`endif

  int   checks = 0;
  int   errors = 0;
  res_t exp_r;
  bit   exp_armed = 1'b0;

  always #5 clk = ~clk;

  dd_outgoing_sel dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_flow_id(in_flow_id),
    .in_acked_wnd(in_acked_wnd), .in_rtx_wnd(in_rtx_wnd), .in_wnd_start(in_wnd_start),
    .in_wnd_start_ind(in_wnd_start_ind), .in_wnd_size(in_wnd_size), .in_next_new(in_next_new),
    .out_valid(out_valid), .out_ready(out_ready), .out_flow_id(out_flow_id),
    .out_pkt_val(out_pkt_val), .out_pkt_rtx(out_pkt_rtx), .out_pkt_seq(out_pkt_seq),
    .out_rtx_wnd(out_rtx_wnd), .out_next_new(out_next_new)
`ifdef DD_OUTGOING_STATS_EN
    , .stat_rtx_cnt(stat_rtx_cnt), .stat_new_cnt(stat_new_cnt), .stat_none_cnt(stat_none_cnt)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Walk the window in logical order: first unacked rtx slot wins, else a new
  // segment if next_new lies inside the window, else nothing.
  function automatic res_t model(input txn_t t);
    res_t r;
    int   off = -1;
    int   p;
    r.flow_id = t.flow_id;
    for (int o = 0; o < int'(t.size); o++) begin
      p = (int'(t.ind) + o) % 128;
      if (off < 0 && t.rtx[p] && !t.acked[p]) off = o;
    end
    r.rtxw = t.rtx;
    r.nn   = t.nn;
    r.lat  = 6;
    if (off >= 0) begin
      r.val = 1'b1; r.rtx = 1'b1;
      r.seq = t.start + 32'(off);
      r.rtxw[(int'(t.ind) + off) % 128] = 1'b0;
      r.lat = 3 + off / 32;
    end else if ((t.nn - t.start) < 32'(t.size)) begin
      r.val = 1'b1; r.rtx = 1'b0;
      r.seq = t.nn;
      r.nn  = t.nn + 32'd1;
    end else begin
      r.val = 1'b0; r.rtx = 1'b0; r.seq = '0;
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic txn_t mk(input logic [31:0] start, input logic [6:0] ind, input logic [7:0] size,
                              input logic [31:0] nn, input logic [127:0] rtx, input logic [127:0] acked);
    txn_t t;
    t.flow_id = 10'($urandom);
    t.start = start; t.ind = ind; t.size = size; t.nn = nn; t.rtx = rtx; t.acked = acked;
    return t;
  endfunction

  task automatic drive(input txn_t t);
    in_flow_id = t.flow_id; in_acked_wnd = t.acked; in_rtx_wnd = t.rtx;
    in_wnd_start = t.start; in_wnd_start_ind = t.ind; in_wnd_size = t.size; in_next_new = t.nn;
  endtask

  task automatic run_txn(input txn_t t, input int hold, input bit junk);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_timeout", {127'd0, in_ready}, 128'd1);
    exp_r = model(t);
    drive(t);
    in_valid = 1'b1;
    exp_armed = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("latency", 128'(n), 128'(exp_r.lat));
    if (junk) begin
      drive(mk($urandom, 7'($urandom), 8'($urandom_range(0, 128)), $urandom, rand128(), rand128()));
      in_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("busy_in_ready", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_armed = 1'b0;
    chk("post_hs_out_valid", {127'd0, out_valid}, 128'd0);
    chk("post_hs_in_ready", {127'd0, in_ready}, 128'd1);
`ifdef DD_OUTGOING_STATS_EN
    if (!exp_r.val) exp_none_cnt++;
    else if (exp_r.rtx) exp_rtx_cnt++;
    else exp_new_cnt++;
    chk("stat_rtx", 128'(stat_rtx_cnt), 128'(exp_rtx_cnt));
    chk("stat_new", 128'(stat_new_cnt), 128'(exp_new_cnt));
    chk("stat_none", 128'(stat_none_cnt), 128'(exp_none_cnt));
`endif
  endtask

  // Every cycle a result is presented it must match the model, and the block must stay busy.
  always @(negedge clk) begin
    if (out_valid) begin
      if (!exp_armed) begin
        checks++; errors++;
        $display("FAIL spurious_out_valid actual=1 expected=0");
      end else begin
        chk("out_flow_id", 128'(out_flow_id), 128'(exp_r.flow_id));
        chk("out_pkt_val", 128'(out_pkt_val), 128'(exp_r.val));
        chk("out_pkt_rtx", 128'(out_pkt_rtx), 128'(exp_r.rtx));
        chk("out_pkt_seq", 128'(out_pkt_seq), 128'(exp_r.seq));
        chk("out_rtx_wnd", out_rtx_wnd, exp_r.rtxw);
        chk("out_next_new", 128'(out_next_new), 128'(exp_r.nn));
        chk("emit_in_ready", 128'(in_ready), 128'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t_empty, t_wrap, t_ign, t_seqw, t_full, t_zero, t;
    res_t r;
    logic [127:0] b;

    t_empty = mk(32'd100, 7'd5, 8'd10, 32'd104, '0, '0);
    t_wrap  = mk(32'd1000, 7'd120, 8'd16, 32'd1016, 128'd1 << 3, '0);
    t_ign   = mk(32'd500, 7'd0, 8'd8, 32'd508, (128'd1 << 0) | (128'd1 << 20), 128'd1);
    t_seqw  = mk(32'hFFFF_FFFE, 7'd0, 8'd4, 32'hFFFF_FFFF, '0, '0);
    t_full  = mk(32'd7000, 7'd64, 8'd128, 32'd7128, 128'd1 << 63, '0);
    t_zero  = mk(32'd50, 7'd9, 8'd0, 32'd50, '1, '0);

    r = model(t_empty);
    chk("pin_empty_seq", 128'(r.seq), 128'd104);
    chk("pin_empty_nn", 128'(r.nn), 128'd105);
    r = model(t_wrap);
    chk("pin_wrap_seq", 128'(r.seq), 128'd1011);
    chk("pin_wrap_rtxw", r.rtxw, 128'd0);
    r = model(t_ign);
    chk("pin_ign_val", 128'(r.val), 128'd0);
    r = model(t_seqw);
    chk("pin_seqw_nn", 128'(r.nn), 128'd0);
    r = model(t_full);
    chk("pin_full_seq", 128'(r.seq), 128'd7127);
    chk("pin_full_lat", 128'(r.lat), 128'd6);

    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_pkt_val", 128'(out_pkt_val), 128'd0);
    chk("rst_pkt_seq", 128'(out_pkt_seq), 128'd0);
    chk("rst_rtx_wnd", out_rtx_wnd, 128'd0);
    chk("rst_next_new", 128'(out_next_new), 128'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(t_empty, 0, 1'b0);
    run_txn(t_wrap, 0, 1'b0);
    run_txn(t_ign, 1, 1'b0);
    run_txn(t_seqw, 0, 1'b0);
    run_txn(t_full, 0, 1'b0);
    run_txn(t_zero, 0, 1'b0);
    run_txn(t_wrap, 5, 1'b1);

    // Reset in the middle of a scan must discard the context asynchronously.
    @(negedge clk);
    drive(mk(32'd1, 7'd0, 8'd128, 32'd1, '0, '0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midscan_in_ready", 128'(in_ready), 128'd1);
    chk("midscan_out_valid", 128'(out_valid), 128'd0);
    chk("midscan_pkt_val", 128'(out_pkt_val), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef DD_OUTGOING_STATS_EN
    exp_rtx_cnt = 0; exp_new_cnt = 0; exp_none_cnt = 0;
`endif
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("post_reset_idle", 128'(in_ready), 128'd1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = rand128() & rand128() & rand128() & rand128();
        2:       b = rand128() & rand128();
        default: b = rand128();
      endcase
      t = mk(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom,
             7'($urandom), 8'($urandom_range(0, 128)), 32'd0, b,
             ($urandom_range(0, 1) == 1) ? rand128() : rand128() & rand128());
      t.nn = t.start + 32'($urandom_range(0, 140));
      run_txn(t, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
